piso_bit_serializer: RTL and testbench

PISO_BIT_SERIALIZER -- requirements
Module: piso_bit_serializer

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_bit_serializer.sv | 120 ++++++++++++
 tb/tb_piso_bit_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg
//   Shared definitions for the parallel-in / serial-out bit serializer.
//   - piso_state_t       : FSM state encoding (IDLE, SHIFT)
//   - PISO_DEFAULT_WIDTH : default number of bits per parallel word
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

endpackage : piso_pkg

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer
//   Accepts a WIDTH-bit word over a valid/ready handshake and streams it out
//   one bit per clock. A new word can be accepted on the edge that retires
//   the last bit of the current word, so consecutive words go out gaplessly.
//
//   Build option:
//     PISO_BIT_SERIALIZER_LSB_FIRST_EN  defined   -> bit 0 is sent first
//                                       undefined -> bit WIDTH-1 is sent first
//     Latency, handshake and out_valid timing are the same in both builds.
//
//   Ports:
//     clk        in   single clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   in_data holds a word to send
//     in_ready   out  word is accepted this cycle when in_valid is also high
//     in_data    in   WIDTH-bit parallel word
//     out_bit    out  serial bit stream (0 whenever out_valid is 0)
//     out_valid  out  out_bit carries a payload bit this cycle
module piso_bit_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_bit,
  output logic             out_valid
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  piso_state_t      state;
  piso_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic             rdy_en;
  logic             accept;
  logic             last_bit;
  logic             head_bit;

  assign accept   = in_valid && in_ready;
  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);

`ifdef PISO_BIT_SERIALIZER_LSB_FIRST_EN
  assign head_bit = shreg[0];
`else
  assign head_bit = shreg[WIDTH-1];
`endif

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  // An accept on the last-bit edge keeps us in SHIFT for the next word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output logic ----
  // rdy_en holds in_ready low while reset is asserted and up to the first
  // clock edge after release, even though the FSM already sits in IDLE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rdy_en;
      end
      SHIFT: begin
        in_ready  = rdy_en && (cnt == LAST_CNT);
        out_valid = 1'b1;
        out_bit   = head_bit;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // ---- shift register / bit counter ----
  // The counter stops at WIDTH-1 and returns to 0; it never runs past the
  // word even when WIDTH is not a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shreg  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        shreg <= in_data;
        cnt   <= '0;
      end else if (state == SHIFT) begin
`ifdef PISO_BIT_SERIALIZER_LSB_FIRST_EN
        shreg <= shreg >> 1;
`else
        shreg <= shreg << 1;
`endif
        cnt <= last_bit ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule : piso_bit_serializer

// File: tb/tb_piso_bit_serializer.sv
// tb_piso_bit_serializer
//   Directed bench for piso_bit_serializer (WIDTH=8). Inputs are driven and
//   outputs sampled on the falling clock edge. Words are chosen per build so
//   the expected serial stream is the same for MSB-first and LSB-first
//   builds (the LSB-first build sends the bit-reversed word).
module tb_piso_bit_serializer;

  localparam int WIDTH = 8;

`ifdef PISO_BIT_SERIALIZER_LSB_FIRST_EN
  localparam logic [7:0] W_SINGLE = 8'h0B;
  localparam logic [7:0] W_B2B_A  = 8'hAB;
  localparam logic [7:0] W_B2B_B  = 8'hB0;
`else
  localparam logic [7:0] W_SINGLE = 8'hD0;
  localparam logic [7:0] W_B2B_A  = 8'hD5;
  localparam logic [7:0] W_B2B_B  = 8'h0D;
`endif
  // A5 and 3C are bit-palindromes: same stream in both builds.
  localparam logic [7:0] W_MID_A = 8'hA5;
  localparam logic [7:0] W_MID_B = 8'h3C;

  // Expected streams, first transmitted bit in the MSB position.
  localparam logic [7:0]  S_SINGLE = 8'b1101_0000;
  localparam logic [15:0] S_B2B    = 16'b1101_0101_0000_1101;
  localparam logic [15:0] S_MID    = 16'b1010_0101_0011_1100;

  logic             tb_clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_bit;
  logic             out_valid;

  int        tests = 0;
  int        fails = 0;
  logic [3:0] hist;
  int        hits;

  always #5 tb_clk = ~tb_clk;

  piso_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (tb_clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_bit   (out_bit),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and feed a 1101 overlapping detector
  // with every valid serial bit, as the downstream block would see it.
  task automatic tick();
    logic [3:0] nh;
    @(negedge tb_clk);
    if (out_valid === 1'b1) begin
      nh   = {hist[2:0], out_bit};
      hist = nh;
      if (nh == 4'b1101) hits++;
    end
  endtask

  task automatic chk_bit(input string tag, input int i, input logic eb, input logic er);
    chk($sformatf("%s_valid[%0d]", tag, i), {31'd0, out_valid}, 32'd1);
    chk($sformatf("%s_bit[%0d]", tag, i), {31'd0, out_bit}, {31'd0, eb});
    chk($sformatf("%s_ready[%0d]", tag, i), {31'd0, in_ready}, {31'd0, er});
  endtask

  task automatic chk_idle(input string tag, input logic er);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_bit"}, {31'd0, out_bit}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, {31'd0, er});
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    hist     = '0;
    hits     = 0;

    // Reset state
    #2 rst_n = 1'b0;
    #1 chk_idle("reset", 1'b0);
    tick();
    tick();
    chk_idle("reset_held", 1'b0);
    rst_n = 1'b1;
    #1 chk_idle("release_pre_edge", 1'b0);

    // Idle for 20 cycles with in_valid low
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("idle[%0d]", i), 1'b1);
    end

    // Single word, MSB-first D0 (LSB-first build: 0B)
    in_valid = 1'b1;
    in_data  = W_SINGLE;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_bit("single", i, S_SINGLE[7-i], (i == 7));
      if (i == 0) begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
      end
    end
    tick();
    chk_idle("single_end", 1'b1);
    tick();
    chk_idle("single_end2", 1'b1);

    // Back-to-back words with in_valid held high
    hist = '0;
    hits = 0;
    in_valid = 1'b1;
    in_data  = W_B2B_A;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_bit("b2b", i, S_B2B[15-i], ((i % 8) == 7));
      if (i == 0) in_data = W_B2B_B;
      if (i == 8) in_valid = 1'b0;
    end
    tick();
    chk_idle("b2b_end", 1'b1);
    chk("b2b_detect_hits", hits, 32'd2);

    // New word offered mid-word: current word completes untouched
    in_valid = 1'b1;
    in_data  = W_MID_A;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_bit("mid", i, S_MID[15-i], ((i % 8) == 7));
      if (i == 0) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = W_MID_B;
      end
      if (i == 8) in_valid = 1'b0;
    end
    tick();
    chk_idle("mid_end", 1'b1);

    // Reset during bit 3 of FF
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bit("abort", i, 1'b1, 1'b0);
      if (i == 0) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1 chk_idle("abort_reset", 1'b0);
    tick();
    rst_n = 1'b1;
    #1 chk_idle("abort_release_pre_edge", 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle($sformatf("abort_after[%0d]", i), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_piso_bit_serializer
